ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit_pkg.sv | 24 ++
 rtl/ifetch_unit_if.sv | 11 +
 rtl/ifetch_unit_icache_dm.sv | 53 +++++
 rtl/ifetch_unit.sv | 130 +++++++++++++
 tb/tb_ifetch_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared FSM encoding, compressed-detect constant and cache field widths
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } fetch_state_t;

  // Low two bits of byte 0 equal to this mark a full 32-bit instruction.
  localparam logic [1:0] UNCOMP_LO = 2'b11;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return ADDR_W - 1 - idx_w(lines);
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - byte memory port between the fetch unit and the memory arbiter
interface ifetch_unit_if;
  logic        mem_req;
  logic        mem_grant;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_din;

  modport master (output mem_req, mem_a, mem_wr, input mem_grant, mem_din);
  modport slave  (input mem_req, mem_a, mem_wr, output mem_grant, mem_din);
endinterface

// File: rtl/ifetch_unit_icache_dm.sv
// rtl/ifetch_unit_icache_dm.sv - direct-mapped instruction cache, combinational lookup, registered fill
module icache_dm
  import ifetch_unit_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [INST_W-1:0] hit_inst,
  output logic              hit_c,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              fill_c
);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES);

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  cflag;
  logic [TW-1:0]     tags  [LINES];
  logic [INST_W-1:0] insts [LINES];
  logic [IW-1:0]     l_idx;
  logic [IW-1:0]     f_idx;
  logic              unused_lsb;

  assign l_idx      = lookup_addr[IW:1];
  assign f_idx      = fill_addr[IW:1];
  assign unused_lsb = lookup_addr[0] ^ fill_addr[0];

  assign hit      = valid[l_idx] && (tags[l_idx] == lookup_addr[ADDR_W-1:IW+1]);
  assign hit_inst = insts[l_idx];
  assign hit_c    = cflag[l_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (fill) begin
      valid[f_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[f_idx]  <= fill_addr[ADDR_W-1:IW+1];
      insts[f_idx] <= fill_inst;
      cflag[f_idx] <= fill_c;
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - byte-serial instruction fetch with compressed detect
// Optional direct-mapped cache enabled by defining IFETCH_ICACHE_EN.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int ICACHE_LINES = 16
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  input  logic          clear,
  input  logic          if_enable,
  input  logic [31:0]   if_addr,
  output logic          inst_ready,
  output logic          is_c,
  output logic [31:0]   inst_val,
  ifetch_unit_if.master mem
);
  fetch_state_t state, state_nx;
  logic [31:0] fetch_pc;
  logic [1:0]  cnt;
  logic [23:0] asm_q;
  logic [31:0] inst_q;
  logic        c_q;
  logic        req_q, req_c;
  logic [31:0] a_q, a_c;
  logic [1:0]  a_off;
  logic        hit, hit_c;
  logic [31:0] hit_inst;
  logic        asm_c, last_byte, accept_miss, accept_hit;

  assign asm_c       = (asm_q[1:0] != UNCOMP_LO);
  assign last_byte   = (cnt == 2'd3) || ((cnt == 2'd1) && asm_c);
  assign accept_hit  = (state == S_IDLE) && if_enable && !clear && hit;
  assign accept_miss = (state == S_IDLE) && if_enable && !clear && !hit && mem.mem_grant;

  always_comb begin
    state_nx = state;
    req_c    = 1'b0;
    a_c      = if_addr;
    a_off    = cnt + 2'd1;
    case (state)
      S_IDLE: begin
        req_c = if_enable && !hit;
        if (accept_hit)       state_nx = S_DONE;
        else if (accept_miss) state_nx = S_FETCH;
      end
      S_FETCH: begin
        req_c = 1'b1;
        // Once the last needed byte is in flight, the address stops stepping.
        if (last_byte) a_off = cnt;
        a_c = fetch_pc + {30'd0, a_off};
        if (last_byte) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (clear) begin
      state_nx = S_IDLE;
      req_c    = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= S_IDLE;
      fetch_pc <= '0;
      cnt      <= '0;
      asm_q    <= '0;
      inst_q   <= '0;
      c_q      <= 1'b0;
      req_q    <= 1'b0;
      a_q      <= '0;
    end else if (rdy_in) begin
      state <= state_nx;
      req_q <= req_c;
      a_q   <= a_c;
      if (accept_miss || accept_hit) begin
        fetch_pc <= if_addr;
        cnt      <= 2'd0;
      end
      if (state == S_FETCH && !clear) begin
        cnt <= cnt + 2'd1;
        case (cnt)
          2'd0:    asm_q[7:0]   <= mem.mem_din;
          2'd1:    asm_q[15:8]  <= mem.mem_din;
          2'd2:    asm_q[23:16] <= mem.mem_din;
          default: ;
        endcase
        if (last_byte) begin
          c_q    <= asm_c;
          inst_q <= asm_c ? {16'h0000, mem.mem_din, asm_q[7:0]} : {mem.mem_din, asm_q[23:0]};
        end
      end
      if (accept_hit) begin
        c_q    <= hit_c;
        inst_q <= hit_inst;
      end
    end
  end

  // While stalled the port replays the last driven request so read data stays aligned.
  assign mem.mem_req = rst_n_in && (rdy_in ? req_c : req_q);
  assign mem.mem_a   = !rst_n_in ? 32'd0 : (rdy_in ? a_c : a_q);
  assign mem.mem_wr  = 1'b0;
  assign inst_ready  = (state == S_DONE) && rdy_in && !clear;
  assign inst_val    = inst_q;
  assign is_c        = c_q;

`ifdef IFETCH_ICACHE_EN
  icache_dm #(.LINES(ICACHE_LINES)) u_icache (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .lookup_addr(if_addr),
    .hit        (hit),
    .hit_inst   (hit_inst),
    .hit_c      (hit_c),
    .fill       (inst_ready),
    .fill_addr  (fetch_pc),
    .fill_inst  (inst_q),
    .fill_c     (c_q)
  );
`else
  logic unused_lines;
  assign unused_lines = (ICACHE_LINES != 0);
  assign hit          = 1'b0;
  assign hit_inst     = '0;
  assign hit_c        = 1'b0;
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed and randomized checks of ifetch_unit against a behavioural model
module tb_ifetch_unit;
  localparam int LINES = 16;
  localparam int IW    = $clog2(LINES);
`ifdef IFETCH_ICACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, rdy_in, clear, if_enable;
  logic [31:0] if_addr;
  logic        inst_ready, is_c;
  logic [31:0] inst_val;

  ifetch_unit_if bus ();

  ifetch_unit #(.ICACHE_LINES(LINES)) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .rdy_in    (rdy_in),
    .clear     (clear),
    .if_enable (if_enable),
    .if_addr   (if_addr),
    .inst_ready(inst_ready),
    .is_c      (is_c),
    .inst_val  (inst_val),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  // Byte memory: data returned one cycle after its address is driven.
  logic [7:0] mem [1024];
  always @(posedge clk) bus.mem_din <= mem[bus.mem_a[9:0]];

  // Cache model: what each line would hold after completed fetches.
  bit          mv [LINES];
  logic [31:0] ma [LINES];
  logic [31:0] mi [LINES];
  bit          mc [LINES];

  int checks = 0;
  int errors = 0;
  int lat_o;
  int seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endtask

  task automatic run_fetch(input logic [31:0] addr, input int stall_at_in, input int stall_len,
                           output int lat_out);
    logic [7:0]  b [4];
    logic [31:0] a, exp_inst, prev_a, obs_val;
    bit          c, hit, got, obs_c;
    int          lat, t, idx, stall_at;
    for (int k = 0; k < 4; k++) begin
      a    = addr + 32'(k);
      b[k] = mem[a[9:0]];
    end
    c        = (b[0][1:0] != 2'b11);
    exp_inst = c ? {16'h0000, b[1], b[0]} : {b[3], b[2], b[1], b[0]};
    idx      = int'(addr[IW:1]);
    hit      = CACHE_ON && mv[idx] && (ma[idx] == addr);
    if (hit) begin
      exp_inst = mi[idx];
      c        = mc[idx];
    end
    stall_at = hit ? 1 : stall_at_in;
    lat      = (hit ? 1 : (c ? 3 : 5)) + stall_len;

    @(negedge clk);
    clear = 1'b0; bus.mem_grant = 1'b1; rdy_in = 1'b1; if_enable = 1'b1; if_addr = addr;
    #1;
    chk("req_T", 32'(bus.mem_req), 32'(!hit));
    if (!hit) chk("mem_a_T", bus.mem_a, addr);
    prev_a  = bus.mem_a;
    got     = 1'b0;
    t       = 0;
    obs_val = '0;
    obs_c   = 1'b0;
    while (!got && t < lat + 6) begin
      @(negedge clk);
      t++;
      if_enable = 1'b0;
      rdy_in    = !(stall_len > 0 && t >= stall_at && t < stall_at + stall_len);
      #1;
      if (!rdy_in) chk("stall_a", bus.mem_a, prev_a);
      else if (!hit && stall_len == 0 && t <= (c ? 1 : 3)) chk("step_a", bus.mem_a, addr + 32'(t));
      prev_a = bus.mem_a;
      if (inst_ready) begin
        got     = 1'b1;
        obs_val = inst_val;
        obs_c   = is_c;
      end
    end
    chk("ready_lat", 32'(t), 32'(lat));
    chk("inst_val", obs_val, exp_inst);
    chk("is_c", 32'(obs_c), 32'(c));
    @(negedge clk);
    #1;
    chk("pulse_one", 32'(inst_ready), 32'd0);
    chk("hold_val", inst_val, exp_inst);
    mv[idx] = 1'b1;
    ma[idx] = addr;
    mi[idx] = exp_inst;
    mc[idx] = c;
    lat_out = t;
  endtask

  initial begin
    rst_n = 1'b0; rdy_in = 1'b1; clear = 1'b0; if_enable = 1'b1; if_addr = 32'h104;
    bus.mem_grant = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(inst_ready), 32'd0);
    chk("rst_is_c", 32'(is_c), 32'd0);
    chk("rst_val", inst_val, 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_a", bus.mem_a, 32'd0);
    chk("rst_wr", 32'(bus.mem_wr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; if_enable = 1'b0;

    // 32-bit fetch
    mem[10'h100] = 8'h13; mem[10'h101] = 8'h05; mem[10'h102] = 8'hA0; mem[10'h103] = 8'h00;
    run_fetch(32'h100, 0, 0, lat_o);
    chk("dir32_val", inst_val, 32'h00A00513);
    chk("dir32_c", 32'(is_c), 32'd0);

    // compressed fetch
    mem[10'h102] = 8'h05; mem[10'h103] = 8'h45;
    run_fetch(32'h102, 0, 0, lat_o);
    chk("dir16_val", inst_val, 32'h00004505);
    chk("dir16_c", 32'(is_c), 32'd1);

    // clear at T+2, new fetch accepted the following cycle
    @(negedge clk); if_enable = 1'b1; if_addr = 32'h200; #1;
    chk("clr_T_a", bus.mem_a, 32'h200);
    @(negedge clk); if_enable = 1'b0; #1;
    @(negedge clk); clear = 1'b1; #1;
    chk("clr_req", 32'(bus.mem_req), 32'd0);
    chk("clr_ready", 32'(inst_ready), 32'd0);
    run_fetch(32'h300, 0, 0, lat_o);
    run_fetch(32'h200, 0, 0, lat_o);

    // grant withheld for four cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.mem_grant = 1'b0; if_enable = 1'b1; if_addr = 32'h140; #1;
      chk("gnt_req", 32'(bus.mem_req), 32'd1);
      chk("gnt_a", bus.mem_a, 32'h140);
    end
    run_fetch(32'h140, 0, 0, lat_o);

    // three-cycle stall during fetch
    run_fetch(32'h100, 2, 3, lat_o);

`ifdef IFETCH_ICACHE_EN
    run_fetch(32'h100, 0, 0, lat_o);
    run_fetch(32'h100, 0, 0, lat_o);
    chk("cache_hit_lat", 32'(lat_o), 32'd1);
    @(negedge clk); rst_n = 1'b0; #1;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    run_fetch(32'h100, 0, 0, lat_o);
    chk("cache_miss_lat", 32'(lat_o), 32'd5);
`endif

    // asynchronous reset in the middle of a fetch
    @(negedge clk); if_enable = 1'b1; if_addr = 32'h180; #1;
    @(negedge clk); if_enable = 1'b0; #1;
    @(negedge clk); #1; rst_n = 1'b0; #1;
    chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_a", bus.mem_a, 32'd0);
    chk("mid_rst_ready", 32'(inst_ready), 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (inst_ready) seen++;
    end
    chk("mid_rst_no_pulse", 32'(seen), 32'd0);

    // address wrap across 2^32
    mem[10'h3FE] = 8'h13;
    run_fetch(32'hFFFF_FFFE, 0, 0, lat_o);

    // randomized fetches
    for (int n = 0; n < 24; n++) begin
      logic [31:0] ra;
      int          slen;
      ra   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF80 + (32'($urandom_range(0, 63)) << 1))
                                         : (32'($urandom_range(0, 63)) << 1);
      slen = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_fetch(ra, int'($urandom_range(1, 2)), slen, lat_o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
